bram_burst_ctrl: RTL and testbench
==================================

BRAM_BURST_CTRL -- requirements
Module: bram_burst_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, BRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, BRAM word width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1 (1=write burst, 0=read burst), cmd_addr in ADDR_W (start address), cmd_len in ADDR_W (burst length minus one).
REQ-006 SHALL have ports wr_data in DATA_W, wr_valid in 1, wr_ready out 1 (write-data stream).
REQ-007 SHALL have ports rd_data out DATA_W, rd_valid out 1, rd_ready in 1 (read-data stream).
REQ-008 SHALL have ports bram_we out 1, bram_addr out ADDR_W, bram_din out DATA_W, bram_dout in DATA_W (one BRAM port; dout registered, 1-cycle read latency).
REQ-009 SHALL have ports busy out 1 (state not IDLE) and done out 1 (one-cycle pulse at burst completion).

Function
REQ-010 SHALL implement states IDLE, WRITE, READ, DRAIN; cmd_ready=1 only in IDLE.
REQ-011 Command handshake SHALL occur on the cycle cmd_valid&cmd_ready; address, length and direction are latched then; next state WRITE or READ.
REQ-012 Burst length SHALL be cmd_len+1 words (1..2^ADDR_W); word address SHALL increment by 1 per beat, wrapping from 2^ADDR_W-1 to 0.
REQ-013 bram_we, bram_addr, bram_din SHALL be registered outputs.
REQ-014 In WRITE, wr_ready SHALL be 1 while beats remain; each accepted wr beat SHALL produce exactly one cycle with bram_we=1, bram_addr=current address, bram_din=wr_data in the following cycle; no write without an accepted beat.
REQ-015 After the last write beat is accepted: wr_ready=0 from the next cycle, final bram_we cycle occurs, done=1 in the cycle after the final bram_we, return to IDLE.
REQ-016 In READ, a read issue SHALL drive bram_we=0 and bram_addr=current address; bram_dout SHALL be captured into an internal 3-entry FIFO in the cycle after issue.
REQ-017 A read SHALL issue only when FIFO occupancy plus in-flight reads is below 3; no BRAM data SHALL ever be dropped.
REQ-018 rd_valid SHALL equal FIFO non-empty; rd_data SHALL be FIFO head; pop on rd_valid&rd_ready; rd_data SHALL hold stable while rd_valid&!rd_ready.
REQ-019 With rd_ready held high, READ SHALL sustain one word per cycle; first rd_valid SHALL assert 3 cycles after the command handshake cycle.
REQ-020 After the last read issues, state SHALL move to DRAIN; done=1 in the cycle after the last word is popped, then IDLE.
REQ-021 Simultaneous FIFO push and pop SHALL keep occupancy unchanged and preserve order.
REQ-022 bram_we SHALL be 0 in IDLE, READ and DRAIN.
REQ-023 Commands presented while busy SHALL be ignored (not latched) until cmd_ready=1.

Reset
REQ-024 While reset=0: state=IDLE, cmd_ready=1, wr_ready=0, rd_valid=0, bram_we=0, bram_addr=0, bram_din=0, rd_data=0, busy=0, done=0, FIFO empty, in-flight count 0.
REQ-025 Reset asserted mid-burst SHALL abort immediately (asynchronously), with no further bram_we and no further rd_valid; BRAM contents already written remain.
REQ-026 After reset release, the first command SHALL be accepted normally on the next handshake.

Verification
REQ-027 Write addr=0x010, len=3, data A,B,C,D back-to-back -> bram_we on 4 consecutive cycles at 0x010..0x013 with A..D; done one cycle after last.
REQ-028 Read addr=0x010, len=3, rd_ready=1 -> rd_data A,B,C,D on 4 consecutive cycles, first rd_valid 3 cycles after handshake, done after D.
REQ-029 Write addr=0x3FE, len=3 -> addresses 0x3FE,0x3FF,0x000,0x001 (wrap).
REQ-030 Read len=7 with rd_ready toggling 1-in-3 -> all 8 words in order, none lost or duplicated, rd_data stable while stalled.
REQ-031 Write with wr_valid gaps (2 idle cycles between beats) -> bram_we only for accepted beats; contents correct on readback.
REQ-032 Reset pulled low after 2 of 5 write beats -> bram_we=0 immediately, outputs at reset values; addresses +2..+4 unmodified.

Source files
------------

// File: rtl/bram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// bram_burst_ctrl
//   Turns single write or read burst commands into word accesses on one
//   synchronous BRAM port. Write bursts take data from a valid/ready stream.
//   Read bursts return data through a 3-entry skid FIFO, so back-pressure on
//   rd_ready never drops a word that has already been fetched.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only when idle)
//   cmd_write                  1 = write burst, 0 = read burst
//   cmd_addr, cmd_len          start word address, burst length minus one
//   wr_data/wr_valid/wr_ready  write-data stream
//   rd_data/rd_valid/rd_ready  read-data stream (FIFO head)
//   bram_we/addr/din/dout      BRAM port, dout has 1-cycle latency
//   busy                       controller not idle
//   done                       one-cycle pulse when a burst completes
// -----------------------------------------------------------------------------
module bram_burst_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W-1:0] cmd_len,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [DATA_W-1:0] bram_din,
   input  logic [DATA_W-1:0] bram_dout,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr;       // next address to write / issue
   logic [ADDR_W-1:0]   r_cnt;        // beats left after the current one
   logic                r_wr_ready;
   logic                r_bram_we;
   logic [ADDR_W-1:0]   r_bram_addr;
   logic [DATA_W-1:0]   r_bram_din;
   logic                r_done;
   // [0]: bram_addr this cycle is a read issue; [1]: bram_dout this cycle is valid
   logic [1:0]          r_vld_pipe;
   logic [DATA_W-1:0]   r_fifo [3];
   logic [1:0]          r_wptr;
   logic [1:0]          r_rptr;
   logic [1:0]          r_count;

   logic                w_hs;
   logic                w_push;
   logic                w_pop;
   logic [2:0]          w_occ_next;
   logic                w_room;
   logic                w_issue;
   logic                w_last_pop;

   assign w_hs   = cmd_valid & (r_state == S_IDLE);
   assign w_push = r_vld_pipe[1];
   assign w_pop  = (r_count != 2'd0) & rd_ready;

   // Words that will be owed a FIFO slot after this edge: FIFO content after
   // push/pop plus the read already on the BRAM address bus. A new issue is
   // allowed only while that total leaves a free slot, which still lets a
   // continuously drained FIFO run at one word per cycle.
   assign w_occ_next = {1'b0, r_count} + {2'b00, w_push} + {2'b00, r_vld_pipe[0]}
                       - {2'b00, w_pop};
   assign w_room     = (w_occ_next < 3'd3);

   // The first read is issued on the handshake edge itself so data shows up
   // three cycles after the command is accepted.
   assign w_issue    = (w_hs & ~cmd_write) | ((r_state == S_READ) & w_room);

   assign w_last_pop = w_pop & (r_count == 2'd1) & ~w_push & ~r_vld_pipe[0];

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign wr_ready  = r_wr_ready;
   assign rd_valid  = (r_count != 2'd0);
   assign rd_data   = r_fifo[r_rptr];
   assign bram_we   = r_bram_we;
   assign bram_addr = r_bram_addr;
   assign bram_din  = r_bram_din;
   assign done      = r_done;

   // Control FSM with registered BRAM and handshake outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_cnt       <= '0;
         r_wr_ready  <= 1'b0;
         r_bram_we   <= 1'b0;
         r_bram_addr <= '0;
         r_bram_din  <= '0;
         r_done      <= 1'b0;
         r_vld_pipe  <= '0;
      end else begin
         r_done     <= 1'b0;
         r_bram_we  <= 1'b0;
         r_vld_pipe <= {r_vld_pipe[0], w_issue};
         case (r_state)
            S_IDLE: begin
               if (w_hs) begin
                  r_cnt <= cmd_len;
                  if (cmd_write) begin
                     r_addr     <= cmd_addr;
                     r_wr_ready <= 1'b1;
                     r_state    <= S_WRITE;
                  end else begin
                     r_bram_addr <= cmd_addr;
                     r_addr      <= cmd_addr + ONE;
                     r_state     <= (cmd_len == '0) ? S_DRAIN : S_READ;
                  end
               end
            end
            S_WRITE: begin
               // wr_ready low here means the last beat's write is on the bus
               if (!r_wr_ready) begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end else if (wr_valid) begin
                  r_bram_we   <= 1'b1;
                  r_bram_addr <= r_addr;
                  r_bram_din  <= wr_data;
                  r_addr      <= r_addr + ONE;
                  r_cnt       <= r_cnt - ONE;
                  if (r_cnt == '0) r_wr_ready <= 1'b0;
               end
            end
            S_READ: begin
               if (w_room) begin
                  r_bram_addr <= r_addr;
                  r_addr      <= r_addr + ONE;
                  r_cnt       <= r_cnt - ONE;
                  if (r_cnt == ONE) r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_last_pop) begin
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Read-data FIFO, 3 entries, circular pointers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 3; i++) r_fifo[i] <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_fifo[r_wptr] <= bram_dout;
            r_wptr         <= (r_wptr == 2'd2) ? 2'd0 : r_wptr + 2'd1;
         end
         if (w_pop) r_rptr <= (r_rptr == 2'd2) ? 2'd0 : r_rptr + 2'd1;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

endmodule

// File: tb/tb_bram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bram_burst_ctrl
//   Scoreboard bench: stimulus tasks push expected BRAM writes and read words
//   into queues computed from a plain reference memory; a negedge monitor pops
//   and compares whenever the DUT writes the BRAM or presents read data.
// -----------------------------------------------------------------------------
module tb_bram_burst_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [9:0]  cmd_addr, cmd_len;
   logic [15:0] wr_data;
   logic        wr_valid, wr_ready;
   logic [15:0] rd_data;
   logic        rd_valid, rd_ready;
   logic        bram_we;
   logic [9:0]  bram_addr;
   logic [15:0] bram_din, bram_dout;
   logic        busy, done;

   bram_burst_ctrl #(.ADDR_W(10), .DATA_W(16)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
      .bram_dout(bram_dout), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // BRAM model with preload port; dout registered (1-cycle latency)
   logic [15:0] mem [0:1023];
   logic        pre_en = 1'b0;
   logic [9:0]  pre_addr = '0;
   logic [15:0] pre_data = '0;
   always @(posedge clk) begin
      if (pre_en)       mem[pre_addr]  <= pre_data;
      else if (bram_we) mem[bram_addr] <= bram_din;
      bram_dout <= mem[bram_addr];
   end

   // Reference model: what the memory should hold
   logic [15:0] ref_mem [0:1023];

   typedef struct {
      logic [9:0]  addr;
      logic [15:0] data;
      int          cyc;
   } wexp_t;

   wexp_t       exp_wr_q [$];
   logic [15:0] exp_rd_q [$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int hs_cnt = 0, exp_hs = 0, hs_cyc = 0;
   int first_we_cyc = -1, last_we_cyc = -1;
   int first_pop_cyc = -1, last_pop_cyc = -1;
   int done_cyc = -1;
   bit first_rd_pend = 1'b0;
   wexp_t mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   task automatic fail_line(input string n);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", n, cyc);
   endtask

   // Monitor: compares DUT output activity against the scoreboard queues
   always @(negedge clk) begin
      if (reset) begin
         if (cmd_valid && cmd_ready) begin
            hs_cnt++;
            hs_cyc        = cyc;
            first_rd_pend = 1'b1;
            first_we_cyc  = -1;
            first_pop_cyc = -1;
         end
         if (bram_we) begin
            if (exp_wr_q.size() == 0) fail_line("unexpected_bram_we");
            else begin
               mon_e = exp_wr_q.pop_front();
               chk("we_addr", bram_addr, mon_e.addr);
               chk("we_data", bram_din, mon_e.data);
               chk("we_latency", cyc, mon_e.cyc + 1);
            end
            if (first_we_cyc < 0) first_we_cyc = cyc;
            last_we_cyc = cyc;
         end
         if (rd_valid) begin
            if (first_rd_pend) begin
               chk("rd_first_latency", cyc, hs_cyc + 3);
               first_rd_pend = 1'b0;
            end
            // head must match whether or not it is popped: covers stall stability
            if (exp_rd_q.size() == 0) fail_line("unexpected_rd_valid");
            else begin
               chk("rd_data", rd_data, exp_rd_q[0]);
               if (rd_ready) void'(exp_rd_q.pop_front());
            end
            if (rd_ready) begin
               if (first_pop_cyc < 0) first_pop_cyc = cyc;
               last_pop_cyc = cyc;
            end
         end
         if (done) done_cyc = cyc;
      end
   end

   task automatic send_cmd(input bit w, input logic [9:0] a, input logic [9:0] l);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
      exp_hs++;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (cmd_ready) begin ok = 1'b1; break; end
      end
      if (!ok) fail_line("cmd_handshake_timeout");
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string n);
      bit got;
      got = 1'b0;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (done) begin got = 1'b1; break; end
      end
      if (!got) fail_line(n);
      #1;
   endtask

   task automatic wr_beat(input logic [9:0] a, input logic [15:0] d);
      bit acc;
      acc = 1'b0;
      wr_valid = 1'b1; wr_data = d;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (wr_ready) begin
            acc = 1'b1;
            exp_wr_q.push_back('{a, d, cyc});
            ref_mem[a] = d;
         end
         @(posedge clk); #1;
         if (acc) break;
      end
      if (!acc) fail_line("wr_accept_timeout");
   endtask

   task automatic wr_burst(input logic [9:0] a, input int len, input int gap,
                           input bit fixed, input bit junk);
      logic [9:0]  wa;
      logic [15:0] d;
      send_cmd(1'b1, a, 10'(len));
      if (junk) begin
         cmd_valid = 1'b1; cmd_write = 1'($urandom);
         cmd_addr = 10'($urandom); cmd_len = 10'($urandom);
      end
      for (int i = 0; i <= len; i++) begin
         if (i > 0 && gap > 0) begin
            wr_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
         end
         wa = a + 10'(i);
         d  = fixed ? 16'(16'hAAAA + i * 16'h1111) : 16'($urandom);
         wr_beat(wa, d);
      end
      wr_valid  = 1'b0;
      cmd_valid = 1'b0;
      wait_done("wr_done_timeout");
      chk("wr_done_latency", done_cyc, last_we_cyc + 1);
      if (gap == 0) chk("wr_back_to_back", last_we_cyc - first_we_cyc, len);
      chk("wr_queue_empty", exp_wr_q.size(), 0);
      chk("handshake_count", hs_cnt, exp_hs);
   endtask

   // mode 0: rd_ready high, 1: ready 1-in-3, 2: random ready
   task automatic rd_burst(input logic [9:0] a, input int len, input int mode);
      logic [9:0] ra;
      bit got;
      for (int i = 0; i <= len; i++) begin
         ra = a + 10'(i);
         exp_rd_q.push_back(ref_mem[ra]);
      end
      send_cmd(1'b0, a, 10'(len));
      got = 1'b0;
      for (int k = 0; k < (len + 1) * 8 + 40; k++) begin
         case (mode)
            0:       rd_ready = 1'b1;
            1:       rd_ready = (k % 3 == 0);
            default: rd_ready = 1'($urandom);
         endcase
         @(negedge clk);
         if (done) begin got = 1'b1; break; end
         @(posedge clk); #1;
      end
      rd_ready = 1'b0;
      #1;
      if (!got) fail_line("rd_done_timeout");
      chk("rd_done_latency", done_cyc, last_pop_cyc + 1);
      if (mode == 0) chk("rd_one_per_cycle", last_pop_cyc - first_pop_cyc, len);
      chk("rd_queue_empty", exp_rd_q.size(), 0);
      chk("handshake_count", hs_cnt, exp_hs);
   endtask

   task automatic chk_rst();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_bram_we", bram_we, 0);
      chk("rst_bram_addr", bram_addr, 0);
      chk("rst_bram_din", bram_din, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
   endtask

   initial begin
      logic [9:0] ra;
      reset = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
      #2 reset = 1'b0;

      // preload BRAM and reference with random contents while in reset
      for (int i = 0; i < 1024; i++) begin
         @(posedge clk); #1;
         pre_en = 1'b1; pre_addr = 10'(i); pre_data = 16'($urandom);
         ref_mem[i] = pre_data;
      end
      @(posedge clk); #1;
      pre_en = 1'b0;
      @(negedge clk);
      chk_rst();
      @(posedge clk); #1;
      reset = 1'b1;

      // fixed pattern write then read back at full rate
      wr_burst(10'h010, 3, 0, 1'b1, 1'b0);
      rd_burst(10'h010, 3, 0);

      // address wrap at the top of memory
      wr_burst(10'h3FE, 3, 0, 1'b0, 1'b0);
      rd_burst(10'h3FE, 3, 0);

      // stalled reader: ready one cycle in three
      rd_burst(10'h000, 7, 1);

      // write with two idle cycles between beats, busy-time commands ignored
      wr_burst(10'h200, 4, 2, 1'b0, 1'b1);
      rd_burst(10'h200, 4, 2);

      // single-word bursts
      wr_burst(10'h123, 0, 0, 1'b0, 1'b0);
      rd_burst(10'h123, 0, 0);

      // random mix
      for (int n = 0; n < 12; n++) begin
         if ($urandom_range(0, 1) == 1)
            wr_burst(10'($urandom), $urandom_range(0, 12), $urandom_range(0, 2),
                     1'b0, 1'($urandom));
         else
            rd_burst(10'($urandom), $urandom_range(0, 12), $urandom_range(0, 2));
      end

      // reset in the middle of a 5-beat write after 2 beats
      ra = 10'h155;
      send_cmd(1'b1, ra, 10'd4);
      wr_beat(ra, 16'h1234);
      wr_beat(ra + 10'd1, 16'h5678);
      wr_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      wr_valid = 1'b1; wr_data = 16'hDEAD;
      #2 reset = 1'b0;
      #1;
      chk_rst();
      chk("rst_abort_queue", exp_wr_q.size(), 0);
      wr_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      rd_burst(ra, 4, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
